// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered binary-to-one-hot decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Callers zero-extend the code to MAX_IN_W and truncate the result to their OUT_W.
    function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [MAX_IN_W-1:0] code);
        return MAX_OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/decoder_scan_ctr.sv
// Scan code counter plus dwell counter; the top decides when to load, hold or advance.
module decoder_scan_ctr
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int DWELL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            advance,
    input  logic            holding,
    output logic [IN_W-1:0] s,
    output logic [IN_W-1:0] s_next,
    output logic            dwell_met
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [IN_W-1:0] s_q, s_d;
    logic [7:0]      dwell_q, dwell_d;

    // S wraps naturally because OUT_W is exactly 2**IN_W.
    always_comb begin
        s_d     = s_q;
        dwell_d = dwell_q;
        if (advance) begin
            s_d     = s_q + 1'b1;
            dwell_d = 8'd0;
        end else if (load) begin
            dwell_d = 8'd0;
        end else if (holding && dwell_q != 8'hff) begin
            dwell_d = dwell_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            dwell_q <= 8'd0;
        end else begin
            s_q     <= s_d;
            dwell_q <= dwell_d;
        end
    end

    assign s         = s_q;
    assign s_next    = s_q + 1'b1;
    assign dwell_met = (dwell_q >= DWELL_LAST);

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2**N one-hot decoder with valid/ready handshake and a self-running scan mode.
// Optional invariant checker and sticky err port enabled by DECODER_ONEHOT_CHECK_EN.
module decoder_nx2n_seq
    import decoder_pkg::*;
#(
    parameter int  IN_W  = 3,
    parameter int  DWELL = 1,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [IN_W-1:0]  out_code,
`ifdef DECODER_ONEHOT_CHECK_EN
    output logic             err,
`endif
    output state_e           dbg_state
);

    // Handshake: a word moves when valid and ready are both high in the same cycle;
    // valid never waits on ready, and the held word is stable until it drains.

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic [IN_W-1:0]  code_q, code_d;

    logic            drain, take, scan_adv, ctr_load, holding, dwell_met;
    logic [IN_W-1:0] scan_s, scan_s_next;

    assign drain    = valid_q && out_ready;
    assign take     = (state_q == IDLE) || drain;
    assign scan_adv = drain && (mode_q == MODE_SCAN) && dwell_met;
    assign holding  = (state_q == HOLD) && (mode_q == MODE_SCAN);

    decoder_scan_ctr #(
        .IN_W  (IN_W),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .advance   (scan_adv),
        .holding   (holding),
        .s         (scan_s),
        .s_next    (scan_s_next),
        .dwell_met (dwell_met)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        code_d   = code_q;
        ctr_load = 1'b0;
        // mode only matters when the register is free to take a new word.
        if (take) begin
            if (mode == MODE_DIRECT) begin
                if (in_valid) begin
                    state_d  = HOLD;
                    mode_d   = MODE_DIRECT;
                    valid_d  = 1'b1;
                    code_d   = in_code;
                    onehot_d = OUT_W'(onehot_of(MAX_IN_W'(in_code)));
                end else begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    onehot_d = '0;
                end
            end else if (state_q == IDLE || mode_q == MODE_DIRECT) begin
                state_d  = HOLD;
                mode_d   = MODE_SCAN;
                valid_d  = 1'b1;
                code_d   = scan_s;
                onehot_d = OUT_W'(onehot_of(MAX_IN_W'(scan_s)));
                ctr_load = 1'b1;
            end else if (scan_adv) begin
                state_d  = HOLD;
                valid_d  = 1'b1;
                code_d   = scan_s_next;
                onehot_d = OUT_W'(onehot_of(MAX_IN_W'(scan_s_next)));
            end else begin
                // Drained before the dwell elapsed: bubble, then the same code re-presents.
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE_DIRECT;
            valid_q  <= 1'b0;
            onehot_q <= '0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            code_q   <= code_d;
        end
    end

    assign in_ready   = rst_n && (mode == MODE_DIRECT) && take;
    assign out_valid  = valid_q;
    assign out_onehot = onehot_q;
    assign out_code   = code_q;
    assign dbg_state  = state_q;

`ifdef DECODER_ONEHOT_CHECK_EN
    logic err_q, err_d, viol;

    always_comb begin
        viol = 1'b0;
        if (valid_q) begin
            viol = ($countones(onehot_q) != 1)
                || (onehot_q != OUT_W'(onehot_of(MAX_IN_W'(code_q))));
        end else begin
            viol = (onehot_q != '0);
        end
        err_d = err_q | viol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed bench for decoder_nx2n_seq: a 3-bit instance with DWELL=3 and a 4-bit instance with DWELL=1.
module tb_decoder_nx2n_seq;
    import decoder_pkg::*;

    logic clk;
    logic rst_n;

    logic        mode, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_code, out_code;
    logic [7:0]  out_onehot;
    state_e      st3;

    logic        m4, iv4, ir4, ov4, or4;
    logic [3:0]  ic4, oc4;
    logic [15:0] oh4;
    state_e      st4;

`ifdef DECODER_ONEHOT_CHECK_EN
    logic err3, err4;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_oh [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    decoder_nx2n_seq #(.IN_W(3), .DWELL(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
`ifdef DECODER_ONEHOT_CHECK_EN
        .err        (err3),
`endif
        .dbg_state  (st3)
    );

    decoder_nx2n_seq #(.IN_W(4), .DWELL(1)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (m4),
        .in_valid   (iv4),
        .in_ready   (ir4),
        .in_code    (ic4),
        .out_valid  (ov4),
        .out_ready  (or4),
        .out_onehot (oh4),
        .out_code   (oc4),
`ifdef DECODER_ONEHOT_CHECK_EN
        .err        (err4),
`endif
        .dbg_state  (st4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        mode = MODE_DIRECT; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
        m4 = MODE_DIRECT; iv4 = 1'b0; ic4 = '0; or4 = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_onehot", out_onehot, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_state", st3, IDLE);
        chk("rst4_out_valid", ov4, 0);
        chk("rst4_in_ready", ir4, 0);
        chk("rst4_state", st4, IDLE);
`ifdef DECODER_ONEHOT_CHECK_EN
        chk("rst_err3", err3, 0);
        chk("rst_err4", err4, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("idle_in_ready", in_ready, 1);

        // 1: direct mode, one code per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            #1 chk("t1_in_ready", in_ready, 1);
            tick();
            chk("t1_out_valid", out_valid, 1);
            chk("t1_out_onehot", out_onehot, exp_oh[i]);
            chk("t1_out_code", out_code, i);
        end
        in_valid = 1'b0;
        tick();
        chk("t1_drain_valid", out_valid, 0);
        chk("t1_drain_onehot", out_onehot, 0);
        chk("t1_drain_state", st3, IDLE);

        // 2: backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'd5;
        tick();
        chk("t2_first_onehot", out_onehot, 8'h20);
        chk("t2_first_state", st3, HOLD);
        in_code = 3'd2;
        #1 chk("t2_stall_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall_onehot", out_onehot, 8'h20);
            chk("t2_stall_code", out_code, 5);
            chk("t2_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("t2_release_in_ready", in_ready, 1);
        tick();
        chk("t2_next_onehot", out_onehot, 8'h04);
        chk("t2_next_code", out_code, 2);
        in_valid = 1'b0;
        tick();
        chk("t2_empty_valid", out_valid, 0);

        // 3: scan with DWELL=3, consumer takes each code on its last dwell cycle
        out_ready = 1'b0;
        mode      = MODE_SCAN;
        in_valid  = 1'b1;
        #1 chk("t3_in_ready", in_ready, 0);
        tick();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk("t3_valid", out_valid, 1);
                chk("t3_code", out_code, c);
                chk("t3_onehot", out_onehot, exp_oh[c]);
                out_ready = (k == 2);
                tick();
            end
        end
        chk("t3_wrap_code", out_code, 0);
        chk("t3_wrap_valid", out_valid, 1);

        // 4: early drain of code 4 causes a bubble and re-presents code 4
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk("t4_pre_code", out_code, c);
                out_ready = (k == 2);
                tick();
            end
        end
        chk("t4_code4", out_code, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_bubble_valid", out_valid, 0);
        chk("t4_bubble_onehot", out_onehot, 0);
        tick();
        chk("t4_re_valid", out_valid, 1);
        chk("t4_re_code", out_code, 4);
        chk("t4_re_onehot", out_onehot, 8'h10);
        tick();
        chk("t4_hold_code", out_code, 4);
        tick();
        out_ready = 1'b1;
        tick();
        chk("t4_next_code", out_code, 5);
        chk("t4_next_valid", out_valid, 1);

        // 5: asynchronous reset while code 6 is held
        for (int k = 0; k < 3; k++) begin
            out_ready = (k == 2);
            tick();
        end
        out_ready = 1'b0;
        chk("t5_held_onehot", out_onehot, 8'h40);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_onehot", out_onehot, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t5_restart_valid", out_valid, 1);
        chk("t5_restart_code", out_code, 0);
        chk("t5_restart_onehot", out_onehot, 8'h01);

        // 6: 4-bit instance, direct then scan with DWELL=1
        or4 = 1'b1;
        iv4 = 1'b1;
        ic4 = 4'd15;
        tick();
        chk("t6_oh15", oh4, 16'h8000);
        chk("t6_code15", oc4, 15);
        chk("t6_valid", ov4, 1);
        ic4 = 4'd0;
        tick();
        chk("t6_oh0", oh4, 16'h0001);
        ic4 = 4'd9;
        tick();
        chk("t6_oh9", oh4, 16'h0200);
        chk("t6_state", st4, HOLD);
        iv4 = 1'b0;
        tick();
        chk("t6_drain_valid", ov4, 0);
        m4 = MODE_SCAN;
        tick();
        chk("t6_scan0", oh4, 16'h0001);
        tick();
        chk("t6_scan1", oc4, 1);
        tick();
        chk("t6_scan2", oh4, 16'h0004);
        chk("t6_scan_valid", ov4, 1);

`ifdef DECODER_ONEHOT_CHECK_EN
        m4  = MODE_DIRECT;
        iv4 = 1'b1;
        ic4 = 4'd15;
        tick();
        or4 = 1'b0;
        iv4 = 1'b0;
        chk("t6_err_clean", err4, 0);
        chk("t6_err3_clean", err3, 0);
        force dut4.onehot_q = 16'h8001;
        tick();
        chk("t6_err_set", err4, 1);
        release dut4.onehot_q;
        or4 = 1'b1;
        tick();
        tick();
        chk("t6_err_sticky", err4, 1);
        rst_n = 1'b0;
        #1 chk("t6_err_reset", err4, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
